// File: rtl/seg_display_ctrl.sv
// rtl/seg_display_ctrl.sv - multiplexed seven-segment controller with sequential binary-to-BCD engine
module seg_display_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 16,
  parameter int SCAN_DIV   = 4000,
  parameter int BLINK_DIV  = 250
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    load,
  output logic                    busy,
  output logic                    overflow,
  input  logic [4*NUM_DIGITS-1:0] id_value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blank_lz,
  output logic [3:0]              bcd_data,
  output logic [NUM_DIGITS-1:0]   cn,
  output logic                    dp_n
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);

  // Largest value that fits on the display: 10^NUM_DIGITS - 1.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] MODE_ID    = 2'b00;
  localparam logic [1:0] MODE_NUM   = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;

  // Converter state
  logic [1:0]        state;
  logic [DATA_W-1:0] shreg;
  logic [BCD_W-1:0]  acc;
  logic [BCD_W-2:0]  acc_adj;
  logic [CNT_W-1:0]  iter;
  logic              ovf_pend;
  logic [BCD_W-1:0]  disp;

  // Scan / blink state
  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  div_nxt;
  logic [SEL_W-1:0]  sel;
  logic [SEL_W-1:0]  sel_nxt;
  logic [BLK_W-1:0]  blink_cnt;
  logic [BLK_W-1:0]  blink_cnt_nxt;
  logic              phase_off;
  logic              phase_off_nxt;
  logic              scan_tick;

  // Per-digit decode
  logic [NUM_DIGITS-1:0] lz_blank;
  logic [3:0]            sel_digit;
  logic [3:0]            sel_id;
  logic                  sel_dp;
  logic                  sel_lz;
  logic [3:0]            out_code;
  logic                  out_dpn;

  // Add-3 correction on every BCD nibble >= 5 ahead of the shift. The top
  // bit of the accumulator is shifted out, so only its low three bits of
  // the corrected top nibble are kept (addition mod 8 keeps them exact).
  always_comb begin
    acc_adj = '0;
    for (int k = 0; k < NUM_DIGITS - 1; k++) begin
      acc_adj[4*k +: 4] = (acc[4*k +: 4] >= 4'd5) ? acc[4*k +: 4] + 4'd3 : acc[4*k +: 4];
    end
    acc_adj[BCD_W-2 -: 3] = (acc[BCD_W-1 -: 4] >= 4'd5) ? acc[BCD_W-2 -: 3] + 3'd3
                                                         : acc[BCD_W-2 -: 3];
  end

  // Double-dabble converter FSM with load/busy handshake and display register
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      overflow <= 1'b0;
      shreg    <= '0;
      acc      <= '0;
      iter     <= '0;
      ovf_pend <= 1'b0;
      disp     <= {NUM_DIGITS{4'hF}};
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            shreg    <= data_in;
            acc      <= '0;
            iter     <= '0;
            ovf_pend <= ({{(64-DATA_W){1'b0}}, data_in} > MAX_VAL);
            busy     <= 1'b1;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc   <= {acc_adj, shreg[DATA_W-1]};
          shreg <= {shreg[DATA_W-2:0], 1'b0};
          iter  <= iter + CNT_W'(1);
          if (iter == CNT_W'(DATA_W - 1)) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          disp     <= ovf_pend ? {NUM_DIGITS{4'h9}} : acc;
          overflow <= ovf_pend;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Next-state of the scan divider, digit select and blink phase
  always_comb begin
    scan_tick     = (div == DIV_W'(SCAN_DIV - 1));
    div_nxt       = scan_tick ? '0 : div + DIV_W'(1);
    sel_nxt       = sel;
    blink_cnt_nxt = blink_cnt;
    phase_off_nxt = phase_off;
    if (scan_tick) begin
      sel_nxt = (sel == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel + SEL_W'(1);
      if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
        blink_cnt_nxt = '0;
        phase_off_nxt = ~phase_off;
      end else begin
        blink_cnt_nxt = blink_cnt + BLK_W'(1);
      end
    end
  end

  // Scan divider, digit select and blink phase registers
  always_ff @(posedge clk) begin
    if (reset) begin
      div       <= '0;
      sel       <= '0;
      blink_cnt <= '0;
      phase_off <= 1'b0;
    end else begin
      div       <= div_nxt;
      sel       <= sel_nxt;
      blink_cnt <= blink_cnt_nxt;
      phase_off <= phase_off_nxt;
    end
  end

  // Digits above the highest nonzero digit are leading zeros; digit 0 never is
  always_comb begin : lz_scan
    logic any_nz;
    any_nz   = 1'b0;
    lz_blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      any_nz      = any_nz | (disp[4*k +: 4] != 4'h0);
      lz_blank[k] = (k != 0) && !any_nz;
    end
  end

  // Pick the fields of the digit about to be driven
  always_comb begin
    sel_digit = 4'hF;
    sel_id    = 4'h0;
    sel_dp    = 1'b0;
    sel_lz    = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (sel_nxt == SEL_W'(k)) begin
        sel_digit = disp[4*k +: 4];
        sel_id    = id_value[4*k +: 4];
        sel_dp    = dp_mask[k];
        sel_lz    = lz_blank[k];
      end
    end
  end

  // Mode, blanking and blink rules for the code and decimal point
  always_comb begin
    out_code = 4'hF;
    out_dpn  = 1'b1;
    case (mode)
      MODE_ID: begin
        out_code = sel_id;
        out_dpn  = ~sel_dp;
      end
      MODE_NUM, MODE_BLINK: begin
        if (!(blank_lz && sel_lz)) begin
          out_code = sel_digit;
          out_dpn  = ~sel_dp;
        end
        if (mode == MODE_BLINK && phase_off_nxt) begin
          out_code = 4'hF;
          out_dpn  = 1'b1;
        end
      end
      default: begin
        out_code = 4'hF;
        out_dpn  = 1'b1;
      end
    endcase
  end

  // Registered display outputs, updated every cycle from the next select
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_data <= 4'hF;
      cn       <= '1;
      dp_n     <= 1'b1;
    end else begin
      bcd_data <= out_code;
      cn       <= ~(NUM_DIGITS'(1) << sel_nxt);
      dp_n     <= out_dpn;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb/tb_seg_display_ctrl.sv - self-checking bench for seg_display_ctrl
module tb_seg_display_ctrl;

  localparam int A_ND = 4, A_DW = 16, A_SD = 8, A_BD = 4;
  localparam int B_ND = 3, B_DW = 10, B_SD = 4, B_BD = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [1:0]      mode_a = 2'b01;
  logic [A_DW-1:0] data_a = '0;
  logic            load_a = 1'b0;
  logic            busy_a, ovf_a;
  logic [15:0]     id_a = '0;
  logic [3:0]      dpm_a = '0;
  logic            blz_a = 1'b0;
  logic [3:0]      bcd_a;
  logic [3:0]      cn_a;
  logic            dpn_a;

  logic [1:0]      mode_b = 2'b01;
  logic [B_DW-1:0] data_b = '0;
  logic            load_b = 1'b0;
  logic            busy_b, ovf_b;
  logic [11:0]     id_b = '0;
  logic [2:0]      dpm_b = '0;
  logic            blz_b = 1'b0;
  logic [3:0]      bcd_b;
  logic [2:0]      cn_b;
  logic            dpn_b;

  int     checks = 0;
  int     errors = 0;
  int     kcnt = 0;
  bit     a_valid = 1'b0, b_valid = 1'b0;
  longint a_val = 0, b_val = 0;

  seg_display_ctrl #(.NUM_DIGITS(A_ND), .DATA_W(A_DW), .SCAN_DIV(A_SD), .BLINK_DIV(A_BD)) u_dut_a (
    .clk(clk), .reset(reset), .mode(mode_a), .data_in(data_a), .load(load_a),
    .busy(busy_a), .overflow(ovf_a), .id_value(id_a), .dp_mask(dpm_a),
    .blank_lz(blz_a), .bcd_data(bcd_a), .cn(cn_a), .dp_n(dpn_a)
  );

  seg_display_ctrl #(.NUM_DIGITS(B_ND), .DATA_W(B_DW), .SCAN_DIV(B_SD), .BLINK_DIV(B_BD)) u_dut_b (
    .clk(clk), .reset(reset), .mode(mode_b), .data_in(data_b), .load(load_b),
    .busy(busy_b), .overflow(ovf_b), .id_value(id_b), .dp_mask(dpm_b),
    .blank_lz(blz_b), .bcd_data(bcd_b), .cn(cn_b), .dp_n(dpn_b)
  );

  always #5 clk = ~clk;

  // Clock edges since reset released; the scan position follows from it.
  always @(posedge clk) begin
    if (reset) kcnt <= 0;
    else       kcnt <= kcnt + 1;
  end

  function automatic longint p10(input int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Reference: what the display shows after k edges, from decimal arithmetic.
  function automatic void expect_out(input int nd, input int sd, input int bd, input int k,
                                     input logic [1:0] md, input bit valid, input longint val,
                                     input bit blz, input logic [31:0] id, input logic [7:0] dpm,
                                     output logic [3:0] code, output logic [7:0] cn_e,
                                     output logic dpn);
    int     sel;
    bit     off, ovf, lzb;
    longint p;
    logic [3:0] digit;
    sel  = (k / sd) % nd;
    off  = ((k / (sd * bd)) % 2) == 1;
    p    = p10(sel);
    ovf  = val > (p10(nd) - 1);
    cn_e = 8'hFF;
    cn_e[sel] = 1'b0;
    if (!valid)   digit = 4'hF;
    else if (ovf) digit = 4'h9;
    else          digit = 4'((val / p) % 10);
    lzb  = valid && !ovf && blz && (sel > 0) && (val < p);
    code = 4'hF;
    dpn  = 1'b1;
    case (md)
      2'b00: begin code = id[4*sel +: 4]; dpn = ~dpm[sel]; end
      2'b11: ;
      default: begin
        if (!lzb) begin code = digit; dpn = ~dpm[sel]; end
        if (md == 2'b10 && off) begin code = 4'hF; dpn = 1'b1; end
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (k=%0d)", tag, got, exp, kcnt);
    end
  endtask

  task automatic check_scan_a(input int n);
    logic [3:0] c; logic [7:0] ce; logic d;
    repeat (n) begin
      @(negedge clk);
      expect_out(A_ND, A_SD, A_BD, kcnt, mode_a, a_valid, a_val, blz_a, 32'(id_a), 8'(dpm_a), c, ce, d);
      check("a_bcd", 32'(bcd_a), 32'(c));
      check("a_cn",  32'(cn_a),  32'(ce[3:0]));
      check("a_dp",  32'(dpn_a), 32'(d));
    end
  endtask

  task automatic check_scan_b(input int n);
    logic [3:0] c; logic [7:0] ce; logic d;
    repeat (n) begin
      @(negedge clk);
      expect_out(B_ND, B_SD, B_BD, kcnt, mode_b, b_valid, b_val, blz_b, 32'(id_b), 8'(dpm_b), c, ce, d);
      check("b_bcd", 32'(bcd_b), 32'(c));
      check("b_cn",  32'(cn_b),  32'(ce[2:0]));
      check("b_dp",  32'(dpn_b), 32'(d));
    end
  endtask

  // Issue one load; optionally pulse a second load on busy cycle extra_at.
  task automatic load_a_val(input logic [A_DW-1:0] v, input int extra_at);
    int len;
    @(negedge clk);
    data_a = v;
    load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    len = 0;
    while (busy_a === 1'b1 && len < 100) begin
      len++;
      load_a = (extra_at != 0 && len == extra_at);
      if (load_a) data_a = 16'd4321;
      @(negedge clk);
    end
    load_a = 1'b0;
    check("a_busy_len", 32'(len), 32'(A_DW + 1));
    check("a_ovf", 32'(ovf_a), 32'(v > 16'd9999));
    a_valid = 1'b1;
    a_val   = longint'(v);
    @(negedge clk);
    check("a_busy_idle", 32'(busy_a), 32'd0);
  endtask

  task automatic load_b_val(input logic [B_DW-1:0] v);
    int len;
    @(negedge clk);
    data_b = v;
    load_b = 1'b1;
    @(negedge clk);
    load_b = 1'b0;
    len = 0;
    while (busy_b === 1'b1 && len < 100) begin
      len++;
      @(negedge clk);
    end
    check("b_busy_len", 32'(len), 32'(B_DW + 1));
    check("b_ovf", 32'(ovf_b), 32'(v > 10'd999));
    b_valid = 1'b1;
    b_val   = longint'(v);
  endtask

  initial begin
    logic [A_DW-1:0] v;
    repeat (2) @(negedge clk);
    check("rst_bcd",  32'(bcd_a),  32'hF);
    check("rst_cn",   32'(cn_a),   32'hF);
    check("rst_dp",   32'(dpn_a),  32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_ovf",  32'(ovf_a),  32'd0);
    reset = 1'b0;

    // Blank numeric display and a full scan rotation before any conversion
    check_scan_a(40);

    // Directed conversions
    load_a_val(16'd1234, 0);  check_scan_a(40);
    load_a_val(16'd12345, 0); check_scan_a(36);
    blz_a = 1'b1;
    load_a_val(16'd7, 0);     check_scan_a(36);
    load_a_val(16'd0, 0);     check_scan_a(36);
    load_a_val(16'd555, 5);   check_scan_a(36);
    load_a_val(16'd42, 17);   check_scan_a(36);
    load_a_val(16'd9999, 0);  check_scan_a(36);
    load_a_val(16'd10000, 0); check_scan_a(36);

    // Randomized values, blanking and decimal points
    for (int i = 0; i < 8; i++) begin
      v = (i % 2 == 1) ? 16'($urandom_range(0, 999)) : 16'($urandom_range(0, 65535));
      blz_a = 1'($urandom_range(0, 1));
      dpm_a = 4'($urandom_range(0, 15));
      load_a_val(v, 0);
      check_scan_a(36);
    end

    // ID pattern mode
    mode_a = 2'b00; id_a = 16'h0029; dpm_a = 4'b0010;
    check_scan_a(40);

    // Blink mode across both phases
    mode_a = 2'b10; blz_a = 1'b0; dpm_a = 4'b1111;
    load_a_val(16'($urandom_range(0, 9999)), 0);
    check_scan_a(80);

    // Blank mode
    mode_a = 2'b11;
    check_scan_a(20);
    mode_a = 2'b01;

    // Three-digit, 10-bit instance: select wraps 2->0, saturation boundary
    check_scan_b(16);
    load_b_val(10'd999);  check_scan_b(24);
    load_b_val(10'd1000); check_scan_b(16);
    blz_b = 1'b1; dpm_b = 3'b101;
    for (int i = 0; i < 4; i++) begin
      load_b_val(10'($urandom_range(0, 1023)));
      check_scan_b(16);
    end

    // Reset during SHIFT aborts the conversion and blanks the display
    @(negedge clk);
    data_a = 16'd4321;
    load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_ovf",  32'(ovf_a),  32'd0);
    check("abort_cn",   32'(cn_a),   32'hF);
    repeat (12) @(negedge clk);
    check("abort_busy_stays", 32'(busy_a), 32'd0);
    check_scan_a(36);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
Parametrised multiplexed seven-segment display controller, NUM_DIGITS wide. It converts a DATA_W-bit binary value to BCD with a multi-cycle sequential double-dabble engine and a load/busy handshake. Supports leading-zero blanking, overflow saturation, a per-digit decimal point, a blink mode and a fixed-pattern ID mode. It sits between the datapath and the board's BCD-to-segment decoder and active-low digit-select lines.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8, need not be a power of two)
DATA_W, 16, binary input width (4..32)
SCAN_DIV, 4000, clk cycles per digit-scan step
BLINK_DIV, 250, scan steps per blink half-period

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
mode  in  2  00 ID pattern, 01 numeric, 10 numeric blinking, 11 blank
data_in  in  DATA_W  unsigned value to convert
load  in  1  single-cycle request to convert data_in
busy  out  1  conversion in progress
overflow  out  1  last converted value exceeded 10^NUM_DIGITS-1
id_value  in  4*NUM_DIGITS  fixed BCD pattern for mode 00; nibble k is digit k
dp_mask  in  NUM_DIGITS  decimal point enable per digit
blank_lz  in  1  enable leading-zero blanking in numeric modes
bcd_data  out  4  code of the selected digit; 4'hF means blank
cn  out  NUM_DIGITS  digit select, active-low, one-hot
dp_n  out  1  decimal point, active-low

Behaviour:
- Clocking and reset: single clock domain; reset is synchronous, active-high. Reset values: busy=0, overflow=0, bcd_data=4'hF, cn=all ones, dp_n=1. Converter returns to IDLE, scan divider=0, digit select=0, blink phase=ON. The numeric display register is all 4'hF, so numeric modes show blank until the first conversion completes.
- Converter FSM states: IDLE, SHIFT, DONE.
  - IDLE: load=1 captures data_in, clears the BCD accumulator, sets iteration count=0, asserts busy next cycle and goes to SHIFT.
  - SHIFT: each cycle, add 3 to every accumulator nibble >=5, then shift left one bit, taking the input MSB. After DATA_W iterations go to DONE.
  - DONE: one cycle. Write the numeric display register and overflow, deassert busy, return to IDLE.
  - Timing: load at cycle T gives busy=1 over T+1..T+DATA_W+1. The new value is visible from T+DATA_W+2.
- Handshake: load while busy=1 is ignored; there is no queueing. Load in the same cycle DONE completes is also ignored.
- Overflow: compare the captured value against the constant 10^NUM_DIGITS-1 at capture time. If greater, set overflow=1 and write all digits as 9. Otherwise set overflow=0. The overflow flag holds until the next conversion completes.
- Accumulator width: 4*NUM_DIGITS bits; bits carried out of the top are discarded.
- Leading-zero blanking (modes 01/10, blank_lz=1): every digit above the highest nonzero digit shows 4'hF. Digit 0 is never blanked, so a value of 0 shows as a single 0.
- Scan:
  - scan_tick pulses when the divider reaches SCAN_DIV-1; the divider wraps to 0.
  - Digit select advances on scan_tick and wraps from NUM_DIGITS-1 to 0.
  - bcd_data, cn and dp_n are registered and reflect the new select 1 cycle after scan_tick.
  - cn[sel]=0 and all other cn bits are 1.
- Blink: the phase toggles every BLINK_DIV scan_ticks. In mode 10 the OFF phase forces bcd_data=4'hF and dp_n=1, while cn keeps scanning. The phase counter runs in all modes.
- dp_n=~dp_mask[sel], forced to 1 in mode 11, in the blink OFF phase, and for leading-zero-blanked digits.
- Mode 00 shows id_value nibbles with no blanking logic. Mode 11 gives bcd_data=4'hF and dp_n=1.
- Mode changes affect output on the next output register update. A conversion in flight is unaffected by a mode change.
- Reset asserted during SHIFT aborts the conversion; the display register returns to blank.

Test Plan:
- Reset, then hold: cn cycles 1110,1101,1011,0111 (NUM_DIGITS=4), stepping every 4000 clk; bcd_data=F throughout in mode 01.
- Load 16'd1234 in mode 01: busy high for exactly 17 cycles, overflow=0; afterwards digits 0..3 show 4,3,2,1.
- Load 16'd12345: overflow=1 and all digits show 9. Then load 16'd7 with blank_lz=1: overflow=0, digit0=7, digits1..3=F.
- Load 16'd0 with blank_lz=1 shows only digit0=0. A second load pulsed mid-conversion is ignored: busy length unchanged, first value displayed.
- Mode 00, id_value=16'h0029, dp_mask=4'b0010: digits show 9,2,0,0 and dp_n=0 only while cn=1101. Mode 10: outputs blank for 250 scan steps, then show for 250.
- NUM_DIGITS=3, DATA_W=10: select wraps 2->0, cn never leaves one-hot. Loading 10'd999 gives 9,9,9 with overflow=0; 10'd1000 gives overflow=1.
